// File: rtl/accumulator_mbist.sv
// March C- BIST controller for the accumulator bank: sweeps six March elements
// over every column in parallel and records per-column mismatches and the first failure.
module accumulator_mbist #(
  parameter int unsigned SYSTOLIC_SIZE     = 8,
  parameter int unsigned WEIGHT_WIDTH      = 8,
  parameter int unsigned ACTIVATION_WIDTH  = 8,
  parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int unsigned PATTERN_NUMBER    = 1,
  parameter int unsigned DEPTH             = PATTERN_NUMBER * SYSTOLIC_SIZE,
  parameter int unsigned ADDR_WIDTH        = $clog2(DEPTH)
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        pass,
  output logic                                        wr_en,
  output logic [ADDR_WIDTH-1:0]                       wr_addr,
  output logic [ADDR_WIDTH-1:0]                       rd_addr_bist,
  output logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]  partial_sum_test_flat,
  input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]  partial_sum_outputs_flat,
  output logic [SYSTOLIC_SIZE-1:0]                    fail_col,
  output logic [ADDR_WIDTH-1:0]                       first_fail_addr,
  output logic [2:0]                                  first_fail_elem
);

  localparam int unsigned PSW  = PARTIAL_SUM_WIDTH;
  localparam int unsigned COLS = SYSTOLIC_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [2:0] LAST_ELEM = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [COLS-1:0]         fail_col_q, fail_col_d;
  logic [ADDR_WIDTH-1:0]   ffa_q, ffa_d;
  logic [2:0]              ffe_q, ffe_d;

  logic                    run_c;
  logic                    down_c;
  logic                    last_addr_c;
  logic                    check_en_c;
  logic                    exp_bit_c;
  logic                    wr_bit_c;
  logic [COLS-1:0]         mism_c;

  assign run_c       = (state_q == RUN);
  // Elements 3 and 4 sweep downward; all others sweep upward.
  assign down_c      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign last_addr_c = down_c ? (addr_q == '0) : (addr_q == LAST_ADDR);
  assign check_en_c  = run_c && (elem_q != 3'd0);
  assign exp_bit_c   = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign wr_bit_c    = (elem_q == 3'd1) || (elem_q == 3'd3);

  // Read is asynchronous, so this compares the contents before this cycle's write.
  always_comb begin
    mism_c = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      mism_c[i] = (partial_sum_outputs_flat[i*PSW +: PSW] != {PSW{exp_bit_c}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      elem_q     <= 3'd0;
      addr_q     <= '0;
      fail_col_q <= '0;
      ffa_q      <= '0;
      ffe_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      addr_q     <= addr_d;
      fail_col_q <= fail_col_d;
      ffa_q      <= ffa_d;
      ffe_q      <= ffe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    fail_col_d = fail_col_q;
    ffa_d      = ffa_q;
    ffe_d      = ffe_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          elem_d     = 3'd0;
          addr_d     = '0;
          fail_col_d = '0;
          ffa_d      = '0;
          ffe_d      = 3'd0;
        end
      end
      RUN: begin
        if (check_en_c && (|mism_c)) begin
          fail_col_d = fail_col_q | mism_c;
          // Empty sticky vector means this is the first failing cycle of the run.
          if (fail_col_q == '0) begin
            ffa_d = addr_q;
            ffe_d = elem_q;
          end
        end
        if (last_addr_c) begin
          if (elem_q == LAST_ELEM) begin
            state_d = DONE;
            elem_d  = 3'd0;
            addr_d  = '0;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LAST_ADDR : '0;
          end
        end else begin
          addr_d = down_c ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy                  = run_c;
  assign done                  = (state_q == DONE);
  assign pass                  = done && (fail_col_q == '0);
  assign wr_en                 = run_c && (elem_q != LAST_ELEM);
  assign wr_addr               = run_c ? addr_q : '0;
  assign rd_addr_bist          = run_c ? addr_q : '0;
  assign partial_sum_test_flat = {(PSW*COLS){run_c && wr_bit_c}};
  assign fail_col              = fail_col_q;
  assign first_fail_addr       = ffa_q;
  assign first_fail_elem       = ffe_q;

endmodule

// File: tb/tb_accumulator_mbist.sv
// Directed bench for accumulator_mbist: behavioural accumulator memory with
// selectable stuck-at and coupling faults, plus run-sequence and reset checks.
module tb_accumulator_mbist;

  localparam int unsigned COLS = 8;
  localparam int unsigned PSW  = 19;
  localparam int unsigned DW   = PSW * COLS;
  localparam int unsigned AW   = 3;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic            pass;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr_bist;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic [COLS-1:0] fail_col;
  logic [AW-1:0]   first_fail_addr;
  logic [2:0]      first_fail_elem;

  logic [PSW-1:0]  mem [COLS][8];
  int              fault_mode;
  int              n_checks;
  int              n_pass;
  int              n_fail;

  accumulator_mbist dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .busy                     (busy),
    .done                     (done),
    .pass                     (pass),
    .wr_en                    (wr_en),
    .wr_addr                  (wr_addr),
    .rd_addr_bist             (rd_addr_bist),
    .partial_sum_test_flat    (wdata),
    .partial_sum_outputs_flat (rdata),
    .fail_col                 (fail_col),
    .first_fail_addr          (first_fail_addr),
    .first_fail_elem          (first_fail_elem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory writes at the clock edge; mode 3 couples a 1-write at col6/addr4 into addr3.
  always @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < int'(COLS); c++) mem[c][wr_addr] <= wdata[c*PSW +: PSW];
      if (fault_mode == 3 && wr_addr == 3'd4 && wdata[6*PSW +: PSW] == {PSW{1'b1}})
        mem[6][3] <= {PSW{1'b1}};
    end
  end

  // Asynchronous read; mode 1 = col3/addr5/bit0 SA0, mode 2 = col0/addr2/bit4 SA1.
  always_comb begin
    rdata = '0;
    for (int c = 0; c < int'(COLS); c++) rdata[c*PSW +: PSW] = mem[c][rd_addr_bist];
    if (fault_mode == 1 && rd_addr_bist == 3'd5) rdata[3*PSW + 0] = 1'b0;
    if (fault_mode == 2 && rd_addr_bist == 3'd2) rdata[0*PSW + 4] = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_addrs"}, {24'd0, 1'b0, wr_addr, 1'b0, rd_addr_bist}, 32'd0);
    check({tag, "_wdata_nz"}, 32'(|wdata), 32'd0);
    check({tag, "_fail_col"}, 32'(fail_col), 32'd0);
    check({tag, "_first_fail"}, {25'd0, first_fail_elem, 1'b0, first_fail_addr}, 32'd0);
  endtask

  // Issues a start, then walks the run cycle by cycle comparing the address,
  // write-enable and data sequence with the March C- schedule.
  task automatic run_test(input int restart_at, input int abort_at,
                          output int busy_cycles, output int seq_err, output int cleared);
    int e;
    int ai;
    int expa;
    logic [DW-1:0] expd;
    busy_cycles = 0;
    seq_err     = 0;
    cleared     = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cleared = (fail_col == '0 && first_fail_addr == '0 && first_fail_elem == '0 && !done) ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      if (!busy) break;
      busy_cycles++;
      e    = (k - 1) / 8;
      ai   = (k - 1) % 8;
      expa = (e == 3 || e == 4) ? 7 - ai : ai;
      expd = (e == 1 || e == 3) ? {DW{1'b1}} : '0;
      if (int'(wr_addr) != expa || int'(rd_addr_bist) != expa) seq_err++;
      if (wr_en !== (e < 5)) seq_err++;
      if (e < 5 && wdata !== expd) seq_err++;
      start = (k == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int bc;
    int se;
    int cl;
    n_checks   = 0;
    n_pass     = 0;
    n_fail     = 0;
    fault_mode = 0;
    start      = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_test(0, 0, bc, se, cl);
    check("clean_busy_len", 32'(bc), 32'd48);
    check("clean_seq", 32'(se), 32'd0);
    check("clean_done_pass", {30'd0, done, pass}, 32'h3);
    check("clean_fail_col", 32'(fail_col), 32'h00);
    check("clean_busy_low", 32'(busy), 32'd0);

    fault_mode = 1;
    run_test(0, 0, bc, se, cl);
    check("sa0_fail_col", 32'(fail_col), 32'h08);
    check("sa0_first_addr", 32'(first_fail_addr), 32'd5);
    check("sa0_first_elem", 32'(first_fail_elem), 32'd2);
    check("sa0_done_pass", {30'd0, done, pass}, 32'h2);

    fault_mode = 2;
    run_test(0, 0, bc, se, cl);
    check("restart_cleared", 32'(cl), 32'd1);
    check("sa1_fail_col", 32'(fail_col), 32'h01);
    check("sa1_first_addr", 32'(first_fail_addr), 32'd2);
    check("sa1_first_elem", 32'(first_fail_elem), 32'd1);
    check("sa1_pass", 32'(pass), 32'd0);

    fault_mode = 3;
    run_test(0, 0, bc, se, cl);
    check("cf_fail_col", 32'(fail_col), 32'h40);
    check("cf_first_addr", 32'(first_fail_addr), 32'd3);
    check("cf_first_elem", 32'(first_fail_elem), 32'd3);

    fault_mode = 0;
    run_test(20, 0, bc, se, cl);
    check("ignore_start_len", 32'(bc), 32'd48);
    check("ignore_start_seq", 32'(se), 32'd0);
    check("ignore_start_pass", {30'd0, done, pass}, 32'h3);

    run_test(0, 30, bc, se, cl);
    check("abort_busy_before", 32'(bc), 32'd29);
    #1;
    check_reset_vals("abort");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_test(0, 0, bc, se, cl);
    check("rerun_len", 32'(bc), 32'd48);
    check("rerun_seq", 32'(se), 32'd0);
    check("rerun_pass", {30'd0, done, pass}, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
